decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 264 ++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: decodes RV32 instructions when they are accepted and buffers the
// decoded fields (not the raw bits) in a DEPTH-entry circular FIFO.
module decode_queue #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PC_WIDTH  = 6,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [31:0]          instr_i,
  input  logic [PC_WIDTH-1:0]  pc_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2:0]           op_type_o,
  output logic [3:0]           alu_op_o,
  output logic [6:0]           opcode_o,
  output logic [2:0]           funct3_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [XLEN-1:0]      imm_o,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] illegal_cnt_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  // Opcodes
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpFp   = 7'b1010011;
  localparam logic [6:0] OpcMadd   = 7'b1000011;
  localparam logic [6:0] OpcMsub   = 7'b1000111;
  localparam logic [6:0] OpcNmsub  = 7'b1001011;
  localparam logic [6:0] OpcNmadd  = 7'b1001111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcLoadFp = 7'b0000111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcStFp   = 7'b0100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // Format types
  localparam logic [2:0] TypeR   = 3'd0;
  localparam logic [2:0] TypeI   = 3'd1;
  localparam logic [2:0] TypeS   = 3'd2;
  localparam logic [2:0] TypeB   = 3'd3;
  localparam logic [2:0] TypeU   = 3'd4;
  localparam logic [2:0] TypeJ   = 3'd5;
  localparam logic [2:0] TypeSys = 3'd6;

  // ALU operations
  localparam logic [3:0] AluSll  = 4'd0;
  localparam logic [3:0] AluSrl  = 4'd1;
  localparam logic [3:0] AluSra  = 4'd2;
  localparam logic [3:0] AluAdd  = 4'd3;
  localparam logic [3:0] AluSub  = 4'd4;
  localparam logic [3:0] AluLui  = 4'd5;
  localparam logic [3:0] AluXor  = 4'd6;
  localparam logic [3:0] AluOr   = 4'd7;
  localparam logic [3:0] AluAnd  = 4'd8;
  localparam logic [3:0] AluSlt  = 4'd9;
  localparam logic [3:0] AluSltu = 4'd10;
  localparam logic [3:0] AluLw   = 4'd11;
  localparam logic [3:0] AluSw   = 4'd12;

  // Decode of the incoming instruction
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [2:0]      dec_type;
  logic [3:0]      dec_alu;
  logic            dec_illegal;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Classify the opcode into a format type and flag anything unrecognised.
  always_comb begin
    dec_type    = TypeSys;
    dec_illegal = 1'b0;
    unique case (opcode)
      OpcOp, OpcOpFp, OpcMadd, OpcMsub, OpcNmsub, OpcNmadd: dec_type = TypeR;
      OpcOpImm, OpcJalr, OpcLoad, OpcLoadFp:                dec_type = TypeI;
      OpcStore, OpcStFp:                                    dec_type = TypeS;
      OpcBranch:                                            dec_type = TypeB;
      OpcAuipc, OpcLui:                                     dec_type = TypeU;
      OpcJal:                                               dec_type = TypeJ;
      OpcSystem:                                            dec_type = TypeSys;
      default:                                              dec_illegal = 1'b1;
    endcase
    // Compressed or otherwise non-32-bit encodings are never legal here.
    if (instr_i[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
      dec_type    = TypeSys;
    end
  end

  // Select the ALU operation from opcode, funct3 and instr[30].
  always_comb begin
    dec_alu = AluAdd;
    unique case (opcode)
      OpcOp, OpcOpImm: begin
        unique case (funct3)
          3'b000:  dec_alu = (opcode == OpcOp && instr_i[30]) ? AluSub : AluAdd;
          3'b001:  dec_alu = AluSll;
          3'b010:  dec_alu = AluSlt;
          3'b011:  dec_alu = AluSltu;
          3'b100:  dec_alu = AluXor;
          3'b101:  dec_alu = instr_i[30] ? AluSra : AluSrl;
          3'b110:  dec_alu = AluOr;
          default: dec_alu = AluAnd;
        endcase
      end
      OpcLoad:  dec_alu = AluLw;
      OpcStore: dec_alu = AluSw;
      OpcLui:   dec_alu = AluLui;
      default:  dec_alu = AluAdd;
    endcase
  end

  // Assemble the 32-bit immediate for the decoded format; R and SYS carry none.
  always_comb begin
    imm32 = '0;
    unique case (dec_type)
      TypeI:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      TypeS:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      TypeB:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      TypeU:   imm32 = {instr_i[31:12], 12'b0};
      TypeJ:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign dec_imm = XLEN'($signed(imm32));

  // Queue control
  logic                 push;
  logic                 pop;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CNT_WIDTH-1:0] illegal_cnt_q, illegal_cnt_d;

  // Decoded-entry storage; contents only matter while counted as occupied.
  logic [2:0]          type_mem    [DEPTH];
  logic [3:0]          alu_mem     [DEPTH];
  logic [6:0]          opcode_mem  [DEPTH];
  logic [2:0]          funct3_mem  [DEPTH];
  logic [4:0]          rd_mem      [DEPTH];
  logic [4:0]          rs1_mem     [DEPTH];
  logic [4:0]          rs2_mem     [DEPTH];
  logic [XLEN-1:0]     imm_mem     [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem      [DEPTH];
  logic                illegal_mem [DEPTH];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrMax) ? '0 : ptr + PtrW'(1);
  endfunction

  assign in_ready_o  = (count_q < CntFull);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  // Next-state for pointers, occupancy and the saturating illegal counter.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    if (push && dec_illegal && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Write the decoded entry into the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      type_mem[wr_ptr_q]    <= dec_type;
      alu_mem[wr_ptr_q]     <= dec_alu;
      opcode_mem[wr_ptr_q]  <= opcode;
      funct3_mem[wr_ptr_q]  <= funct3;
      rd_mem[wr_ptr_q]      <= instr_i[11:7];
      rs1_mem[wr_ptr_q]     <= instr_i[19:15];
      rs2_mem[wr_ptr_q]     <= instr_i[24:20];
      imm_mem[wr_ptr_q]     <= dec_imm;
      pc_mem[wr_ptr_q]      <= pc_i;
      illegal_mem[wr_ptr_q] <= dec_illegal;
    end
  end

  // Present the head entry, forced to zero while the queue is empty.
  always_comb begin
    op_type_o = '0;
    alu_op_o  = '0;
    opcode_o  = '0;
    funct3_o  = '0;
    rd_o      = '0;
    rs1_o     = '0;
    rs2_o     = '0;
    imm_o     = '0;
    pc_o      = '0;
    illegal_o = 1'b0;
    if (out_valid_o) begin
      op_type_o = type_mem[rd_ptr_q];
      alu_op_o  = alu_mem[rd_ptr_q];
      opcode_o  = opcode_mem[rd_ptr_q];
      funct3_o  = funct3_mem[rd_ptr_q];
      rd_o      = rd_mem[rd_ptr_q];
      rs1_o     = rs1_mem[rd_ptr_q];
      rs2_o     = rs2_mem[rd_ptr_q];
      imm_o     = imm_mem[rd_ptr_q];
      pc_o      = pc_mem[rd_ptr_q];
      illegal_o = illegal_mem[rd_ptr_q];
    end
  end

  assign illegal_cnt_o = illegal_cnt_q;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed and random traffic checked against a queue-based model.
module tb_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [5:0]  pc = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, illegal;
  logic [2:0]  op_type, funct3;
  logic [3:0]  alu_op;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [5:0]  pc_out;
  logic [7:0]  illegal_cnt;

  logic        in_ready_s, out_valid_s, illegal_s;
  logic [2:0]  op_type_s, funct3_s;
  logic [3:0]  alu_op_s;
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [31:0] imm_s;
  logic [5:0]  pc_out_s;
  logic [1:0]  illegal_cnt_s;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .PC_WIDTH(6), .DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .op_type_o(op_type), .alu_op_o(alu_op), .opcode_o(opcode),
    .funct3_o(funct3), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm), .pc_o(pc_out),
    .illegal_o(illegal), .illegal_cnt_o(illegal_cnt)
  );

  // Same stimulus, 2-bit counter to exercise saturation.
  decode_queue #(.XLEN(32), .PC_WIDTH(6), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
    .instr_i(instr), .pc_i(pc), .flush_i(flush), .out_valid_o(out_valid_s),
    .out_ready_i(out_ready), .op_type_o(op_type_s), .alu_op_o(alu_op_s),
    .opcode_o(opcode_s), .funct3_o(funct3_s), .rd_o(rd_s), .rs1_o(rs1_s), .rs2_o(rs2_s),
    .imm_o(imm_s), .pc_o(pc_out_s), .illegal_o(illegal_s), .illegal_cnt_o(illegal_cnt_s)
  );

  typedef struct packed {
    logic [2:0]  op_type;
    logic [3:0]  alu;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [5:0]  pc;
    logic        illegal;
  } ent_t;

  logic [70:0] dut_head, sat_head;
  assign dut_head = {op_type, alu_op, opcode, funct3, rd, rs1, rs2, imm, pc_out, illegal};
  assign sat_head = {op_type_s, alu_op_s, opcode_s, funct3_s, rd_s, rs1_s, rs2_s, imm_s,
                     pc_out_s, illegal_s};

  ent_t q[$];
  int   mcnt = 0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] legal_ops [16] = '{7'b0110011, 7'b1010011, 7'b1000011, 7'b1000111,
                                 7'b1001011, 7'b1001111, 7'b0010011, 7'b1100111,
                                 7'b0000011, 7'b0000111, 7'b0100011, 7'b0100111,
                                 7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111};

  // Reference decode straight from the format tables, immediates by arithmetic.
  function automatic ent_t ref_decode(input logic [31:0] w, input logic [5:0] p);
    ent_t e;
    int   s, hi, t, v;
    logic [6:0] op;
    op = w[6:0];
    s  = $signed(w);
    e  = '0;
    e.opcode = op;
    e.f3 = w[14:12];
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.pc = p;
    t = 6;
    e.illegal = 1'b1;
    if (w[1:0] == 2'b11) begin
      e.illegal = 1'b0;
      if (op inside {7'b0110011, 7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011,
                     7'b1001111}) t = 0;
      else if (op inside {7'b0010011, 7'b1100111, 7'b0000011, 7'b0000111}) t = 1;
      else if (op inside {7'b0100011, 7'b0100111}) t = 2;
      else if (op == 7'b1100011) t = 3;
      else if (op inside {7'b0010111, 7'b0110111}) t = 4;
      else if (op == 7'b1101111) t = 5;
      else if (op == 7'b1110011) t = 6;
      else e.illegal = 1'b1;
    end
    e.op_type = 3'(t);
    e.alu = 4'd3;
    if (op == 7'b0110011 || op == 7'b0010011) begin
      case (w[14:12])
        3'd0: e.alu = (op == 7'b0110011 && w[30]) ? 4'd4 : 4'd3;
        3'd1: e.alu = 4'd0;
        3'd2: e.alu = 4'd9;
        3'd3: e.alu = 4'd10;
        3'd4: e.alu = 4'd6;
        3'd5: e.alu = w[30] ? 4'd2 : 4'd1;
        3'd6: e.alu = 4'd7;
        default: e.alu = 4'd8;
      endcase
    end else if (op == 7'b0000011) e.alu = 4'd11;
    else if (op == 7'b0100011) e.alu = 4'd12;
    else if (op == 7'b0110111) e.alu = 4'd5;
    hi = s >>> 31;
    case (t)
      1: v = s >>> 20;
      2: begin v = s >>> 25; v = v * 32 + int'(w[11:7]); end
      3: v = hi * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      4: begin v = s >>> 12; v = v * 4096; end
      5: v = hi * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 +
             int'(w[30:21]) * 2;
      default: v = 0;
    endcase
    e.imm = v;
    return e;
  endfunction

  function automatic ent_t exp_head();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  function automatic logic [7:0] exp_cnt();
    return (mcnt > 255) ? 8'hFF : 8'(mcnt);
  endfunction

  function automatic logic [1:0] exp_sat();
    return (mcnt > 3) ? 2'd3 : 2'(mcnt);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = legal_ops[$urandom_range(0, 15)];
    return w;
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] w;
    w = $urandom;
    w[1:0] = 2'(($urandom_range(0, 2)));
    return w;
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, sample after the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] ins,
                     input logic [5:0] p, input logic fl, input logic rdy);
    ent_t e;
    bit   do_push, do_pop;
    @(negedge clk);
    rst_n = r; in_valid = v; instr = ins; pc = p; flush = fl; out_ready = rdy;
    e = ref_decode(ins, p);
    if (!r) begin
      q.delete();
      mcnt = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      do_push = v && (q.size() < DEPTH);
      do_pop  = rdy && (q.size() != 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        if (e.illegal) mcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 0, 32'h0, 6'd0, 0, 0);
    cyc(0, 1, 32'h0, 6'd0, 1, 1);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_flags got %b want 10", {in_ready, out_valid});
    end
    checks++;
    if (dut_head !== 71'd0) begin
      errors++; $display("FAIL reset_head got %h want 0", dut_head);
    end
    checks++;
    if ({illegal_cnt, illegal_cnt_s} !== 10'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0", illegal_cnt, illegal_cnt_s);
    end
  endtask

  task automatic test_directed();
    logic [70:0] first;
    cyc(1, 1, 32'h002081B3, 6'd4, 0, 0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL add_valid got %b want 1", out_valid);
    end
    checks++;
    if ({op_type, alu_op, rd, rs1, rs2, imm, pc_out, illegal} !==
        {3'd0, 4'd3, 5'd3, 5'd1, 5'd2, 32'd0, 6'd4, 1'b0}) begin
      errors++; $display("FAIL add_fields got %h want R/ADD rd3 rs1 rs2 2 pc4", dut_head);
    end
    first = dut_head;
    cyc(1, 1, 32'hFFF00093, 6'($urandom), 0, 0);
    cyc(1, 1, 32'h0020A423, 6'($urandom), 0, 0);
    checks++;
    if (dut_head !== first) begin
      errors++; $display("FAIL head_hold got %h want %h", dut_head, first);
    end
    cyc(1, 1, 32'h40305133, 6'($urandom), 0, 1);
    checks++;
    if ({op_type, alu_op, rd, imm} !== {3'd1, 4'd3, 5'd1, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL addi_fields got %h want I/ADD imm ffffffff", dut_head);
    end
    cyc(1, 0, 32'h0, 6'd0, 0, 1);
    checks++;
    if ({op_type, alu_op, imm} !== {3'd2, 4'd12, 32'd8}) begin
      errors++; $display("FAIL sw_fields got %h want S/SW imm 8", dut_head);
    end
    cyc(1, 0, 32'h0, 6'd0, 0, 1);
    checks++;
    if ({op_type, alu_op, rd} !== {3'd0, 4'd2, 5'd2}) begin
      errors++; $display("FAIL sra_fields got %h want R/SRA rd 2", dut_head);
    end
    cyc(1, 0, 32'h0, 6'd0, 0, 1);
    checks++;
    if ({out_valid, dut_head} !== 72'd0) begin
      errors++; $display("FAIL empty_head got %b/%h want 0", out_valid, dut_head);
    end
  endtask

  task automatic test_full();
    // Move the pointers off zero so the fill wraps.
    cyc(1, 1, rand_instr(), 6'($urandom), 0, 0);
    cyc(1, 1, rand_instr(), 6'($urandom), 0, 0);
    cyc(1, 0, 32'h0, 6'd0, 0, 1);
    cyc(1, 0, 32'h0, 6'd0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, rand_instr(), 6'($urandom), 0, 0);
      checks++;
      if (in_ready !== (i < 3)) begin
        errors++; $display("FAIL full_ready push %0d got %b want %b", i, in_ready, i < 3);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, dut_head} !== {q.size() != 0, exp_head()}) begin
        errors++;
        $display("FAIL drain_order pop %0d got %b/%h want %h", i, out_valid, dut_head,
                 exp_head());
      end
      cyc(1, 0, 32'h0, 6'd0, 0, 1);
    end
  endtask

  task automatic test_illegal();
    cyc(0, 0, 32'h0, 6'd0, 0, 0);
    cyc(1, 1, 32'h00000000, 6'($urandom), 0, 1);
    checks++;
    if ({illegal, op_type, illegal_cnt} !== {1'b1, 3'd6, 8'd1}) begin
      errors++; $display("FAIL ill_zero got %b/%0d/%0d want 1/6/1", illegal, op_type,
                         illegal_cnt);
    end
    cyc(1, 1, 32'hFFFFFFFF, 6'($urandom), 0, 1);
    checks++;
    if ({illegal, op_type, imm, illegal_cnt} !== {1'b1, 3'd6, 32'd0, 8'd2}) begin
      errors++; $display("FAIL ill_ones got %b/%0d/%h/%0d want 1/6/0/2", illegal, op_type,
                         imm, illegal_cnt);
    end
    for (int i = 0; i < 3; i++) cyc(1, 1, rand_illegal(), 6'($urandom), 0, 1);
    checks++;
    if ({illegal_cnt, illegal_cnt_s} !== {8'd5, 2'd3}) begin
      errors++; $display("FAIL ill_sat got %0d/%0d want 5/3", illegal_cnt, illegal_cnt_s);
    end
  endtask

  task automatic test_flush();
    logic [7:0] cnt_before;
    cyc(1, 0, 32'h0, 6'd0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, rand_instr(), 6'($urandom), 0, 0);
    cnt_before = illegal_cnt;
    cyc(1, 1, 32'h00000000, 6'($urandom), 1, 1);
    checks++;
    if ({in_ready, out_valid, dut_head} !== {2'b10, 71'd0}) begin
      errors++; $display("FAIL flush_empty got %b%b/%h want 10/0", in_ready, out_valid,
                         dut_head);
    end
    checks++;
    if (illegal_cnt !== cnt_before) begin
      errors++; $display("FAIL flush_cnt got %0d want %0d", illegal_cnt, cnt_before);
    end
    cyc(1, 1, 32'h00A00513, 6'd9, 0, 0);
    checks++;
    if ({out_valid, dut_head} !== {1'b1, exp_head()}) begin
      errors++; $display("FAIL flush_refill got %h want %h", dut_head, exp_head());
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 32'h0, 6'd0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, rand_instr(), 6'($urandom), 0, 0);
    // Full: the pop goes through, the offered push is refused.
    cyc(1, 1, rand_instr(), 6'($urandom), 0, 1);
    checks++;
    if ({in_ready, dut_head} !== {q.size() < DEPTH, exp_head()}) begin
      errors++; $display("FAIL full_pop got %b/%h want %b/%h", in_ready, dut_head,
                         q.size() < DEPTH, exp_head());
    end
    // Simultaneous push and pop keeps occupancy; one more push refills to full.
    cyc(1, 1, rand_instr(), 6'($urandom), 0, 1);
    cyc(1, 1, rand_instr(), 6'($urandom), 0, 0);
    checks++;
    if ({in_ready, out_valid, dut_head} !== {2'b01, exp_head()} || q.size() != DEPTH) begin
      errors++; $display("FAIL swap_full got %b%b/%h want 01/%h", in_ready, out_valid,
                         dut_head, exp_head());
    end
    cyc(0, 1, 32'hFFFFFFFF, 6'($urandom), 0, 1);
    checks++;
    if ({in_ready, out_valid, illegal_cnt, illegal_cnt_s} !== {2'b10, 8'd0, 2'd0}) begin
      errors++; $display("FAIL midrst got %b%b/%0d want 10/0", in_ready, out_valid,
                         illegal_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, rand_instr(),
          6'($urandom), $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 6);
      checks++;
      if (dut_head !== exp_head()) begin
        errors++; $display("FAIL rand_head cyc %0d got %h want %h", i, dut_head, exp_head());
      end
      checks++;
      if ({in_ready, out_valid, illegal_cnt} !==
          {q.size() < DEPTH, q.size() != 0, exp_cnt()}) begin
        errors++; $display("FAIL rand_ctrl cyc %0d got %b%b/%0d want %b%b/%0d", i, in_ready,
                           out_valid, illegal_cnt, q.size() < DEPTH, q.size() != 0,
                           exp_cnt());
      end
      checks++;
      if ({in_ready_s, out_valid_s, sat_head, illegal_cnt_s} !==
          {q.size() < DEPTH, q.size() != 0, exp_head(), exp_sat()}) begin
        errors++; $display("FAIL rand_sat cyc %0d got %h/%0d want %h/%0d", i, sat_head,
                           illegal_cnt_s, exp_head(), exp_sat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
